// File: rtl/rotary_decoder_if.sv
// Quadrature-pin bundle for rotary_decoder: raw phase pins in, detent event stream out.
// Event stream: rotary_event is a one-cycle strobe with no ready; rotary_right and speed are valid while it is high.
interface rotary_decoder_if;
  logic       rot_a;
  logic       rot_b;
  logic       rotary_event;
  logic       rotary_right;
  logic [4:0] speed;

  modport master (
    input  rot_a,
    input  rot_b,
    output rotary_event,
    output rotary_right,
    output speed
  );

  modport slave (
    output rot_a,
    output rot_b,
    input  rotary_event,
    input  rotary_right,
    input  speed
  );
endinterface

// File: rtl/rotary_decoder.sv
// Quadrature encoder front-end: sync, debounce, quadrature decode to detent events, rate-based speed.
// Optional feature macro ROTARY_ACCEL_EN builds the gap counter and acceleration; otherwise speed is constant.
module rotary_decoder #(
  parameter int STABLE_CYCLES = 5000,
  parameter int ACCEL_WINDOW  = 2500000,
  parameter int BASE_SPEED    = 2,
  parameter int ACCEL_STEP    = 2,
  parameter int MAX_SPEED     = 31
) (
  input logic              clock,
  input logic              reset,
  rotary_decoder_if.master dec_if
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535 || ACCEL_WINDOW < 0 ||
      ACCEL_WINDOW > 16777215 || ACCEL_STEP < 0 || ACCEL_STEP > 31 ||
      MAX_SPEED > 31 || BASE_SPEED < 0 || BASE_SPEED > MAX_SPEED) begin : g_bad_cfg
    $error("rotary_decoder: parameter out of range");
  end

  localparam logic [15:0] STABLE_LIMIT = 16'(STABLE_CYCLES);
  localparam logic [4:0]  SPEED_BASE   = 5'(BASE_SPEED);

  logic [1:0]  s1;
  logic [1:0]  s2;
  logic [1:0]  cand;
  logic [15:0] cnt;
  logic        accepted;
  logic        q1;
  logic        q2;
  logic        q1_d;
  logic        detent;
  logic        dir_right;
  logic        event_r;
  logic        right_r;
  logic [4:0]  speed_r;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= {dec_if.rot_a, dec_if.rot_b};
      s2 <= s1;
    end
  end

  // A pair is accepted only after it has matched cand for STABLE_CYCLES cycles in a row.
  always_ff @(posedge clock) begin
    if (reset) begin
      cand <= 2'b00;
      cnt  <= 16'd0;
    end else if (s2 != cand) begin
      cand <= s2;
      cnt  <= 16'd1;
    end else if (cnt < STABLE_LIMIT) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign accepted = (cnt == STABLE_LIMIT);

  // q1 tracks the both-high/both-low detent phase, q2 remembers which half-step came before it.
  always_ff @(posedge clock) begin
    if (reset) begin
      q1   <= 1'b0;
      q2   <= 1'b0;
      q1_d <= 1'b0;
    end else begin
      q1_d <= q1;
      if (accepted) begin
        case (cand)
          2'b11:   q1 <= 1'b1;
          2'b00:   q1 <= 1'b0;
          2'b01:   q2 <= 1'b1;
          2'b10:   q2 <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign detent    = q1 & ~q1_d;
  assign dir_right = ~q2;

  always_ff @(posedge clock) begin
    if (reset) begin
      event_r <= 1'b0;
      right_r <= 1'b1;
    end else begin
      event_r <= detent;
      if (detent) begin
        right_r <= dir_right;
      end
    end
  end

`ifdef ROTARY_ACCEL_EN
  localparam logic [23:0] WINDOW    = 24'(ACCEL_WINDOW);
  localparam logic [5:0]  STEP      = 6'(ACCEL_STEP);
  localparam logic [5:0]  SPEED_CAP = 6'(MAX_SPEED);

  logic [23:0] gap;
  logic [5:0]  speed_sum;
  logic [4:0]  speed_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      gap <= WINDOW;
    end else if (detent) begin
      gap <= 24'd0;
    end else if (gap < WINDOW) begin
      gap <= gap + 24'd1;
    end
  end

  // Six-bit sum so a large step near the cap saturates instead of wrapping.
  assign speed_sum = {1'b0, speed_r} + STEP;

  always_comb begin
    speed_next = speed_r;
    if (detent) begin
      if (dir_right != right_r) begin
        speed_next = SPEED_BASE;
      end else if (gap < WINDOW) begin
        speed_next = (speed_sum > SPEED_CAP) ? SPEED_CAP[4:0] : speed_sum[4:0];
      end else begin
        speed_next = SPEED_BASE;
      end
    end else if (gap == WINDOW) begin
      speed_next = SPEED_BASE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      speed_r <= SPEED_BASE;
    end else begin
      speed_r <= speed_next;
    end
  end
`else
  assign speed_r = SPEED_BASE;
`endif

  assign dec_if.rotary_event = event_r;
  assign dec_if.rotary_right = right_r;
  assign dec_if.speed        = speed_r;

endmodule

// File: tb/tb_rotary_decoder.sv
// Directed bench for rotary_decoder: reset, both directions, debounce boundary, acceleration and idle decay.
// Speed expectations follow ROTARY_ACCEL_EN so the same bench covers both builds.
module tb_rotary_decoder;
  localparam int STABLE_CYCLES = 4;
  localparam int ACCEL_WINDOW  = 100;
  localparam int BASE_SPEED    = 2;
  localparam int ACCEL_STEP    = 3;
  localparam int MAX_SPEED     = 31;

`ifdef ROTARY_ACCEL_EN
  localparam bit ACCEL_ON = 1'b1;
`else
  localparam bit ACCEL_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  rotary_decoder_if dec_if ();

  rotary_decoder #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .ACCEL_WINDOW  (ACCEL_WINDOW),
    .BASE_SPEED    (BASE_SPEED),
    .ACCEL_STEP    (ACCEL_STEP),
    .MAX_SPEED     (MAX_SPEED)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .dec_if (dec_if)
  );

  // clock/reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
    $fatal(1);
  end

  // event log sampled on the falling edge
  int         ev_cyc_q[$];
  logic       ev_right_q[$];
  logic [4:0] ev_speed_q[$];

  always @(negedge clock) begin
    if (dec_if.rotary_event === 1'b1) begin
      ev_cyc_q.push_back(cyc);
      ev_right_q.push_back(dec_if.rotary_right);
      ev_speed_q.push_back(dec_if.speed);
    end
  end

  // driver tasks
  task automatic clear_log();
    ev_cyc_q.delete();
    ev_right_q.delete();
    ev_speed_q.delete();
  endtask

  task automatic set_pins(input logic [1:0] ab, input int n, output int at);
    @(negedge clock);
    dec_if.rot_a = ab[1];
    dec_if.rot_b = ab[0];
    at = cyc;
    repeat (n - 1) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dec_if.rot_a = 1'b0;
    dec_if.rot_b = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (dec_if.rotary_event !== 1'b0) begin
      failures++; $display("FAIL reset_event: got %b expected 0", dec_if.rotary_event);
    end
    checks++;
    if (dec_if.rotary_right !== 1'b1) begin
      failures++; $display("FAIL reset_right: got %b expected 1", dec_if.rotary_right);
    end
    checks++;
    if (dec_if.speed !== 5'd2) begin
      failures++; $display("FAIL reset_speed: got %0d expected 2", dec_if.speed);
    end
    reset = 1'b0;
    clear_log();
    repeat (50) @(negedge clock);
    checks++;
    if (ev_cyc_q.size() != 0) begin
      failures++; $display("FAIL reset_quiet: got %0d events expected 0", ev_cyc_q.size());
    end
    checks++;
    if (dec_if.speed !== 5'd2 || dec_if.rotary_right !== 1'b1) begin
      failures++; $display("FAIL reset_hold: got speed %0d right %b expected 2/1", dec_if.speed, dec_if.rotary_right);
    end
  endtask

  task automatic test_clockwise();
    int t;
    int t11;
    int lat;
    clear_log();
    set_pins(2'b00, 20, t);
    set_pins(2'b10, 20, t);
    set_pins(2'b11, 20, t11);
    checks++;
    if (ev_cyc_q.size() != 1) begin
      failures++; $display("FAIL cw_count: got %0d events expected 1", ev_cyc_q.size());
    end
    lat = (ev_cyc_q.size() > 0) ? ev_cyc_q[0] - t11 - 1 : -1;
    checks++;
    if (lat != 7) begin
      failures++; $display("FAIL cw_latency: got %0d cycles expected 7", lat);
    end
    checks++;
    if (ev_right_q.size() == 0 || ev_right_q[0] !== 1'b1) begin
      failures++; $display("FAIL cw_right: got %b expected 1", dec_if.rotary_right);
    end
    checks++;
    if (ev_speed_q.size() == 0 || ev_speed_q[0] !== 5'd2) begin
      failures++; $display("FAIL cw_speed: got %0d expected 2", dec_if.speed);
    end
  endtask

  task automatic test_counter_clockwise();
    int t;
    set_pins(2'b10, 20, t);
    set_pins(2'b00, 20, t);
    clear_log();
    set_pins(2'b01, 20, t);
    set_pins(2'b11, 20, t);
    checks++;
    if (ev_cyc_q.size() != 1) begin
      failures++; $display("FAIL ccw_count: got %0d events expected 1", ev_cyc_q.size());
    end
    checks++;
    if (ev_right_q.size() == 0 || ev_right_q[0] !== 1'b0) begin
      failures++; $display("FAIL ccw_right: got %b expected 0", dec_if.rotary_right);
    end
    checks++;
    if (ev_speed_q.size() == 0 || ev_speed_q[0] !== 5'd2) begin
      failures++; $display("FAIL ccw_speed: got %0d expected 2", dec_if.speed);
    end
    checks++;
    if (dec_if.rotary_right !== 1'b0) begin
      failures++; $display("FAIL ccw_right_hold: got %b expected 0", dec_if.rotary_right);
    end
  endtask

  task automatic test_glitch();
    int t;
    set_pins(2'b10, 20, t);
    set_pins(2'b00, 20, t);
    clear_log();
    set_pins(2'b11, 3, t);
    set_pins(2'b00, 30, t);
    checks++;
    if (ev_cyc_q.size() != 0) begin
      failures++; $display("FAIL glitch_reject: got %0d events expected 0", ev_cyc_q.size());
    end
    // q1 must still be low: a clean 10 -> 11 yields one right detent
    clear_log();
    set_pins(2'b10, 20, t);
    set_pins(2'b11, 20, t);
    checks++;
    if (ev_cyc_q.size() != 1 || ev_right_q[0] !== 1'b1 || ev_speed_q[0] !== 5'd2) begin
      failures++; $display("FAIL glitch_recover: got %0d events right %b speed %0d expected 1/1/2",
                           ev_cyc_q.size(), dec_if.rotary_right, dec_if.speed);
    end
  endtask

  task automatic test_stable_boundary();
    int t;
    set_pins(2'b01, 20, t);
    set_pins(2'b00, 20, t);
    clear_log();
    set_pins(2'b11, 4, t);
    set_pins(2'b00, 30, t);
    checks++;
    if (ev_cyc_q.size() != 1) begin
      failures++; $display("FAIL boundary_count: got %0d events expected 1", ev_cyc_q.size());
    end
    checks++;
    if (ev_right_q.size() == 0 || ev_right_q[0] !== 1'b0 || ev_speed_q[0] !== 5'd2) begin
      failures++; $display("FAIL boundary_event: got right %b speed %0d expected 0/2", dec_if.rotary_right, dec_if.speed);
    end
  endtask

  task automatic test_acceleration();
    int t;
    int s;
    int last;
    logic [4:0] exp_q[$];
    clear_log();
    set_pins(2'b10, 15, t);
    set_pins(2'b11, 15, t);
    s = BASE_SPEED;
    exp_q.push_back(5'(s));
    for (int i = 0; i < 12; i++) begin
      set_pins(2'b01, 15, t);
      set_pins(2'b00, 15, t);
      set_pins(2'b10, 15, t);
      set_pins(2'b11, 15, t);
      s = (s + ACCEL_STEP > MAX_SPEED) ? MAX_SPEED : s + ACCEL_STEP;
      exp_q.push_back(ACCEL_ON ? 5'(s) : 5'(BASE_SPEED));
    end
    checks++;
    if (ev_cyc_q.size() != 13) begin
      failures++; $display("FAIL accel_count: got %0d events expected 13", ev_cyc_q.size());
    end
    checks++;
    if (ev_cyc_q.size() < 2 || ev_cyc_q[1] - ev_cyc_q[0] != 60) begin
      failures++; $display("FAIL accel_spacing: got %0d events, first gap wrong, expected 60", ev_cyc_q.size());
    end
    for (int i = 0; i < 13; i++) begin
      if (i < ev_speed_q.size()) begin
        checks++;
        if (ev_speed_q[i] !== exp_q[i] || ev_right_q[i] !== 1'b1) begin
          failures++; $display("FAIL accel_speed[%0d]: got speed %0d right %b expected %0d/1",
                               i, ev_speed_q[i], ev_right_q[i], exp_q[i]);
        end
      end
    end
    last = (ev_cyc_q.size() > 0) ? ev_cyc_q[ev_cyc_q.size() - 1] : cyc;
    while (cyc < last + 95) @(negedge clock);
    checks++;
    if (dec_if.speed !== (ACCEL_ON ? 5'd31 : 5'd2)) begin
      failures++; $display("FAIL idle_before_decay: got %0d expected %0d", dec_if.speed, ACCEL_ON ? 31 : 2);
    end
    while (cyc < last + 150) @(negedge clock);
    checks++;
    if (dec_if.speed !== 5'd2) begin
      failures++; $display("FAIL idle_decay: got %0d expected 2", dec_if.speed);
    end
    checks++;
    if (ev_cyc_q.size() != 13 || dec_if.rotary_right !== 1'b1) begin
      failures++; $display("FAIL idle_quiet: got %0d events right %b expected 13/1", ev_cyc_q.size(), dec_if.rotary_right);
    end
  endtask

  initial begin
    test_reset();
    test_clockwise();
    test_counter_clockwise();
    test_glitch();
    test_stable_boundary();
    test_acceleration();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
